// File: rtl/spi_mem_arbiter_if.sv
// Request/grant bundle between the SPI memory clients and the arbiter.
interface spi_mem_arbiter_if;
  logic req_1;
  logic req_2;
  logic req_3;
  logic req_4;
  logic grant_1;
  logic grant_2;
  logic grant_3;
  logic grant_4;

  // Client side: raises requests, observes grants.
  modport master (
    output req_1, req_2, req_3, req_4,
    input  grant_1, grant_2, grant_3, grant_4
  );

  // Arbiter side: observes requests, drives grants.
  modport slave (
    input  req_1, req_2, req_3, req_4,
    output grant_1, grant_2, grant_3, grant_4
  );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Four-client non-preemptive round-robin arbiter for a shared SPI memory master.
// Grants are registered and one-hot or zero. An owner keeps the memory until it
// drops its request, and a single all-zero cycle always separates two owners.
module spi_mem_arbiter (
  input  logic                clk,
  input  logic                rst,
  spi_mem_arbiter_if.slave    bus
);

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;

  logic [NUM_REQ-1:0] req_vec;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

  assign req_vec = {bus.req_4, bus.req_3, bus.req_2, bus.req_1};

  // Round-robin pick: first requester after last_grant, wrapping 1,2,3,4,1.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      logic [IDX_W-1:0] cand;
      cand = last_grant_q + IDX_W'(i);
      if (!pick_found && req_vec[cand]) begin
        pick_idx   = cand;
        pick_found = 1'b1;
      end
    end
  end

  // Next-state: grant in IDLE, release to IDLE when the owner lets go.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_found) begin
          grant_d      = NUM_REQ'(1) << pick_idx;
          last_grant_d = pick_idx;
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Releasing always passes through IDLE, which forms the CS turnaround gap.
        if ((req_vec & grant_q) == '0) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant and pointer registers; reset points at client 4 so client 1 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.grant_1 = grant_q[0];
  assign bus.grant_2 = grant_q[1];
  assign bus.grant_3 = grant_q[2];
  assign bus.grant_4 = grant_q[3];

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: a cycle-by-cycle vector table plus a
// hand-written round-robin fairness sequence.
module tb_spi_mem_arbiter;

  logic clk;
  logic rst;

  spi_mem_arbiter_if bus ();

  spi_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  typedef struct {
    logic       rst;
    logic [3:0] req;   // {req_4, req_3, req_2, req_1}
    logic [3:0] grant; // expected {grant_4, grant_3, grant_2, grant_1} after the edge
  } vec_t;

  vec_t vecs [$];

  function automatic logic [3:0] grant_vec();
    return {bus.grant_4, bus.grant_3, bus.grant_2, bus.grant_1};
  endfunction

  // Drive inputs away from the edge, then let one rising edge happen and settle.
  task automatic step(input logic r, input logic [3:0] q);
    @(negedge clk);
    rst       = r;
    bus.req_1 = q[0];
    bus.req_2 = q[1];
    bus.req_3 = q[2];
    bus.req_4 = q[3];
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = grant_vec();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: grant=%b expected=%b at %0t", name, got, exp, $time);
    end
    total++;
    if ($countones(got) > 1) begin
      bad++;
      $display("FAIL %s onehot: grant=%b expected at most one bit set", name, got);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g, input int n);
    vec_t v;
    v.rst = r; v.req = q; v.grant = g;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] exp;
    total = 0;
    bad   = 0;
    rst       = 1'b1;
    bus.req_1 = 1'b0;
    bus.req_2 = 1'b0;
    bus.req_3 = 1'b0;
    bus.req_4 = 1'b0;

    // Reset then idle.
    add(1'b1, 4'b0000, 4'b0000, 5);
    add(1'b0, 4'b0000, 4'b0000, 3);
    // Single request, held; one-edge latency.
    add(1'b0, 4'b0001, 4'b0001, 10);
    // No preemption while req_2 then req_3 arrive.
    add(1'b0, 4'b0011, 4'b0001, 1);
    add(1'b0, 4'b0111, 4'b0001, 1);
    // Handover 1 -> gap -> 2.
    add(1'b0, 4'b0110, 4'b0000, 1);
    add(1'b0, 4'b0110, 4'b0010, 2);
    // Handover 2 -> gap -> 3.
    add(1'b0, 4'b0100, 4'b0000, 1);
    add(1'b0, 4'b0100, 4'b0100, 2);
    add(1'b0, 4'b0000, 4'b0000, 2);
    // Pointer wrap: after client 4, client 1 beats client 3.
    add(1'b0, 4'b1000, 4'b1000, 1);
    add(1'b0, 4'b1101, 4'b1000, 1);
    add(1'b0, 4'b0101, 4'b0000, 1);
    add(1'b0, 4'b0101, 4'b0001, 1);
    add(1'b0, 4'b0000, 4'b0000, 1);
    // Lone requester 3 is re-granted after its own transaction.
    add(1'b0, 4'b0100, 4'b0100, 1);
    add(1'b0, 4'b0000, 4'b0000, 1);
    add(1'b0, 4'b0100, 4'b0100, 1);
    add(1'b0, 4'b0110, 4'b0100, 1);
    add(1'b0, 4'b0010, 4'b0000, 1);
    add(1'b0, 4'b0010, 4'b0010, 1);
    // Reset mid-transaction, then client 1 wins over client 2.
    add(1'b1, 4'b0011, 4'b0000, 1);
    add(1'b0, 4'b0011, 4'b0001, 2);
    add(1'b0, 4'b0010, 4'b0000, 1);
    add(1'b0, 4'b0010, 4'b0010, 1);
    add(1'b0, 4'b0000, 4'b0000, 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req);
      check($sformatf("vec%0d", i), vecs[i].grant);
    end

    // Fairness: all four held, owner drops for one cycle after 3 cycles of ownership.
    step(1'b1, 4'b1111);
    check("rr_reset", 4'b0000);
    for (int r = 0; r < 5; r++) begin
      exp = 4'b0001 << (r % 4);
      for (int c = 0; c < 3; c++) begin
        step(1'b0, 4'b1111);
        check($sformatf("rr%0d_own%0d", r, c), exp);
      end
      step(1'b0, 4'b1111 & ~exp);
      check($sformatf("rr%0d_gap", r), 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
- Four-requester, non-preemptive, round-robin arbiter for a single shared SPI memory controller.
- Each client raises its request and holds it for the whole transaction. The arbiter grants exactly one client, which keeps ownership until it drops its request.
- Sits between the SPI memory clients and the SPI memory master mux; the grant vector drives that mux select.

Parameters:
- None. Requester count is fixed at 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high; one clock domain.
- req_1  input  1  request from client 1; level, held high for the whole transaction.
- req_2  input  1  request from client 2.
- req_3  input  1  request from client 3.
- req_4  input  1  request from client 4.
- grant_1  output  1  client 1 owns the memory; registered.
- grant_2  output  1  client 2 owns the memory; registered.
- grant_3  output  1  client 3 owns the memory; registered.
- grant_4  output  1  client 4 owns the memory; registered.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: while rst is high at a rising edge, all grants go to 0, the FSM enters IDLE, and the round-robin pointer last_grant is set to client 4, so client 1 has top priority first.
- Grants are one-hot or all-zero at every cycle. Two grants high at once is an error.
- FSM states:
  - IDLE: no grant.
  - BUSY: one grant held.
- IDLE:
  - If any req is sampled high at edge N, grant_k is 1 after edge N (1-cycle latency) and the FSM moves to BUSY.
  - k = first requesting client searching cyclically from last_grant+1 (order 1,2,3,4,1,...).
  - last_grant <= k.
  - If no req is high, stay in IDLE with grants at 0.
- BUSY:
  - Grant holds while the owner's req stays high. Other requests are ignored (no preemption) but remain pending; requests are not latched.
  - If the owner's req is sampled low at edge M, all grants are 0 after edge M and the FSM returns to IDLE.
  - The next grant is issued no earlier than edge M+1, giving a mandatory ≥1-cycle all-zero gap between owners (chip-select turnaround).
- A request that drops before being granted is not served. No memory of past requests is kept.
- Simultaneous requests in IDLE: resolved by the round-robin order above.
- Owner drops req in the same cycle another client raises it: the gap cycle still occurs, then round-robin selection applies.
- Reset asserted mid-BUSY: grant drops to 0 after that edge, and the pointer returns to client 4.

Test Plan:
- Reset then idle: rst=1 for 5 cycles, then rst=0 with all req=0 → all grants 0 throughout.
- Single request: req_1=1 → grant_1=1 exactly one edge later; req_1 held 10 cycles → grant_1 stays 1, others 0.
- No preemption and handover:
  - During the grant_1 ownership, raise req_2 and then req_3 → grant_1 stays 1.
  - Drop req_1 → grant_1=0 one edge later, then one all-zero cycle, then grant_2=1.
  - Drop req_2 → grant_2=0, gap, then grant_3=1.
- Round-robin fairness: all four reqs held high, each owner drops its req for one cycle after 3 cycles of ownership → grant order 1,2,3,4,1; never two grants high at once.
- Pointer wrap: after grant_4 completes, with req_1 and req_3 both high → grant_1 wins. With only req_3 high after grant_3 completes → grant_3 is granted again.
- Reset mid-transaction: rst=1 while grant_2=1 → all grants 0 after that edge. After release with req_2 and req_1 high → grant_1 first.
